dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between N_CORES matrix-multiply cores and one host port
//  (bench load/dump path). Fixed priority to the host, round-robin among the cores, and one
//  transaction in flight at a time. Sits between the cores' DREAD/DWRITE interfaces and the
//  DMEM instance, replacing the static address-mux select.
// PARAMETERS
//  N_CORES  4   number of core requesters (>=2)
//  AW       16  address width
//  DW       16  data width
// PORTS
//  clk          in   1          system clock, all state on rising edge
//  RESET        in   1          asynchronous, active-high reset
//  core_req     in   N_CORES    per-core request; held until that core's ack
//  core_we      in   N_CORES    per-core 1=write, 0=read; valid with core_req
//  core_addr    in   N_CORES*AW packed addresses, core i at [i*AW +: AW]
//  core_wdata   in   N_CORES*DW packed write data, core i at [i*DW +: DW]
//  core_ack     out  N_CORES    one-hot, 1-cycle completion pulse
//  core_rdata   out  DW         read data, valid in the core_ack cycle, shared by all cores
//  host_req     in   1          host request; held until host_ack
//  host_we      in   1          host 1=write, 0=read
//  host_addr    in   AW         host address
//  host_wdata   in   DW         host write data
//  host_ack     out  1          1-cycle completion pulse
//  host_rdata   out  DW         host read data, valid in the host_ack cycle
//  mem_addr     out  AW         DMEM address
//  mem_wdata    out  DW         DMEM write data
//  mem_we       out  1          DMEM write strobe
//  mem_re       out  1          DMEM read strobe; DMEM returns mem_rdata one cycle later
//  mem_rdata    in   DW         DMEM read data
//  grant_id     out  clog2(N_CORES)+1  current owner: 0..N_CORES-1 = core, N_CORES = host
//  busy         out  1          high in ACCESS and RESP
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; rr_ptr=N_CORES-1, so core 0 has the first turn.
//   Latched request registers are cleared.
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles.
//  IDLE: if host_req, latch the host request. Otherwise, if any core_req, latch the first
//   requesting core scanning rr_ptr+1, rr_ptr+2, ... modulo N_CORES. Latch we/addr/wdata/owner
//   and go to ACCESS. With no requests, stay in IDLE and keep mem_* low.
//  ACCESS (1 cycle): mem_addr and mem_wdata come from the latched values;
//   mem_we = latched we; mem_re = ~latched we. Go to RESP.
//  RESP (1 cycle): assert the owner's ack. On a read, rdata = mem_rdata, driven in the same
//   cycle and registered so it holds until the next read completes. On a write, rdata holds
//   its previous value. Go to IDLE. rr_ptr = owner only when the owner is a core.
//  Latency: request seen in IDLE at cycle t -> mem strobe at t+1 -> ack at t+2. The next grant
//   can be made at t+3, so peak throughput is one access per 3 cycles.
//  Handshake: a requester drops req at the edge where it samples its ack. A req still high in
//   the cycle after ack counts as a new request.
//  A req withdrawn before it is latched is ignored. Once latched, the transaction completes and
//   acks even if req drops.
//  Host priority is absolute; a continuous host_req starves the cores. This is intended for
//   load/dump phases.
//  Requests arriving during ACCESS/RESP wait for IDLE. There is no pre-emption.
//  At most one ack bit (core_ack or host_ack) is high in any cycle. mem_we and mem_re are never
//   high together.
//  Addresses pass through unmodified; no range checking.
//  RESET mid-transaction: abort immediately. No ack is issued, mem_we drops asynchronously, and
//   the FSM restarts from IDLE with rr_ptr=N_CORES-1.
// TESTING
//  1 Assert RESET mid-run -> all outputs 0, busy=0; after release, core 0 wins the first
//    all-core contention.
//  2 DMEM[5]=0x1234; core 2 reads addr 5 -> mem_re at t+1 with mem_addr=5; core_ack=4'b0100
//    and core_rdata=0x1234 at t+2.
//  3 All 4 cores hold req continuously, dropping on ack and re-raising next cycle -> grant
//    order 0,1,2,3,0,1 with acks exactly 3 cycles apart.
//  4 host_req and core_req[1] rise in the same cycle -> host acked first, core 1 acked
//    3 cycles later.
//  5 Core 3 writes 0xBEEF to addr 997, then host reads addr 997 -> one mem_we pulse;
//    host_rdata=0xBEEF.
//  6 Assert RESET during the ACCESS of a core-1 write -> no core_ack, mem_we low from the
//    reset edge, DMEM[addr] unchanged.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, host and DMEM signals around the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16
);
    localparam int unsigned GW = $clog2(N_CORES) + 1;

    logic [N_CORES-1:0]    core_req;
    logic [N_CORES-1:0]    core_we;
    logic [N_CORES*AW-1:0] core_addr;
    logic [N_CORES*DW-1:0] core_wdata;
    logic [N_CORES-1:0]    core_ack;
    logic [DW-1:0]         core_rdata;

    logic                  host_req;
    logic                  host_we;
    logic [AW-1:0]         host_addr;
    logic [DW-1:0]         host_wdata;
    logic                  host_ack;
    logic [DW-1:0]         host_rdata;

    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [DW-1:0]         mem_rdata;

    logic [GW-1:0]         grant_id;
    logic                  busy;

    // Requesters and DMEM side (testbench / surrounding system)
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  core_ack, core_rdata, host_ack, host_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, grant_id, busy
    );

    // Arbiter side
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output core_ack, core_rdata, host_ack, host_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, grant_id, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: host has absolute priority, cores share round-robin,
// one 3-cycle transaction (IDLE -> ACCESS -> RESP) in flight at a time.
module dmem_arbiter #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16
) (
    input  logic          clk,
    input  logic          RESET,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(N_CORES);
    localparam int unsigned GW = CW + 1;
    localparam logic [GW-1:0] HOST_ID = GW'(N_CORES);
    localparam logic [CW-1:0] RR_INIT = CW'(N_CORES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      rr_q, rr_d;
    logic               we_q, we_d;
    logic [GW-1:0]      owner_q, owner_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_re_q, mem_re_d;
    logic [N_CORES-1:0] core_ack_q, core_ack_d;
    logic               host_ack_q, host_ack_d;
    logic [DW-1:0]      core_rdata_q, core_rdata_d;
    logic [DW-1:0]      host_rdata_q, host_rdata_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [CW-1:0]      cand;
    logic [CW-1:0]      pick;
    int unsigned        idx;
    logic               rd_resp_c;

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            rr_q         <= RR_INIT;
            we_q         <= 1'b0;
            owner_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            core_ack_q   <= '0;
            host_ack_q   <= 1'b0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            core_ack_q   <= core_ack_d;
            host_ack_q   <= host_ack_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, grant selection and registered-output next values
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        we_d         = we_q;
        owner_d      = owner_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        core_ack_d   = '0;
        host_ack_d   = 1'b0;
        core_rdata_d = core_rdata_q;
        host_rdata_d = host_rdata_q;
        busy_d       = 1'b0;
        found        = 1'b0;
        pick         = '0;
        cand         = '0;
        idx          = 0;

        // Round-robin scan starting just after the last core served
        for (int unsigned k = 1; k <= N_CORES; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= N_CORES) idx = idx - N_CORES;
            cand = CW'(idx);
            if (!found && bus.core_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.host_req) begin
                    state_d     = ACCESS;
                    busy_d      = 1'b1;
                    owner_d     = HOST_ID;
                    we_d        = bus.host_we;
                    mem_addr_d  = bus.host_addr;
                    mem_wdata_d = bus.host_wdata;
                    mem_we_d    = bus.host_we;
                    mem_re_d    = ~bus.host_we;
                end else if (found) begin
                    state_d     = ACCESS;
                    busy_d      = 1'b1;
                    owner_d     = {1'b0, pick};
                    we_d        = bus.core_we[pick];
                    mem_addr_d  = bus.core_addr[32'(pick) * AW +: AW];
                    mem_wdata_d = bus.core_wdata[32'(pick) * DW +: DW];
                    mem_we_d    = bus.core_we[pick];
                    mem_re_d    = ~bus.core_we[pick];
                end
            end
            ACCESS: begin
                state_d = RESP;
                busy_d  = 1'b1;
                if (owner_q == HOST_ID) host_ack_d = 1'b1;
                else                    core_ack_d[owner_q[CW-1:0]] = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                if (!we_q) begin
                    if (owner_q == HOST_ID) host_rdata_d = bus.mem_rdata;
                    else                    core_rdata_d = bus.mem_rdata;
                end
                if (owner_q != HOST_ID) rr_d = owner_q[CW-1:0];
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data bypasses the holding register during the ack cycle
    assign rd_resp_c = (state_q == RESP) && !we_q;

    assign bus.core_rdata = (rd_resp_c && owner_q != HOST_ID) ? bus.mem_rdata : core_rdata_q;
    assign bus.host_rdata = (rd_resp_c && owner_q == HOST_ID) ? bus.mem_rdata : host_rdata_q;
    assign bus.core_ack   = core_ack_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.grant_id   = owner_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural single-port DMEM.
module tb_dmem_arbiter;
    localparam int unsigned N_CORES = 4;
    localparam int unsigned AW      = 16;
    localparam int unsigned DW      = 16;

    logic clk   = 1'b0;
    logic RESET = 1'b1;

    int n_total = 0;
    int n_pass  = 0;
    int we_pulses = 0;
    int we_snap;

    logic [DW-1:0] mem [0:1023];

    dmem_arbiter_if #(.N_CORES(N_CORES), .AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.N_CORES(N_CORES), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // DMEM model: synchronous write, read data one cycle after mem_re
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end

    always @(posedge clk) if (bus.mem_we) we_pulses <= we_pulses + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host transaction; returns in the host_ack cycle with host_req already dropped
    task automatic host_xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bit got_ack = 0;
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
        for (int c = 0; c < 10 && !got_ack; c++) begin
            tick();
            if (bus.host_ack) got_ack = 1;
        end
        bus.host_req = 1'b0;
        if (!got_ack) check("host_xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_core(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.core_we[i]             = we;
        bus.core_addr[i*AW +: AW]  = addr;
        bus.core_wdata[i*DW +: DW] = wdata;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_core_ack"}, 32'(bus.core_ack), 32'd0);
        check({tag, "_host_ack"}, 32'(bus.host_ack), 32'd0);
        check({tag, "_mem_we"},   32'(bus.mem_we), 32'd0);
        check({tag, "_mem_re"},   32'(bus.mem_re), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_busy"},     32'(bus.busy), 32'd0);
        check({tag, "_grant"},    32'(bus.grant_id), 32'd0);
        check({tag, "_crdata"},   32'(bus.core_rdata), 32'd0);
        check({tag, "_hrdata"},   32'(bus.host_rdata), 32'd0);
    endtask

    int            order [$];
    int            ack_cyc [$];
    logic [3:0]    reraise;

    initial begin
        bus.core_req   = '0;
        bus.core_we    = '0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.mem_rdata  = '0;

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("por");
        RESET = 1'b0;

        // Preload DMEM[5] through the host port
        host_xfer(1'b1, 16'd5, 16'h1234);
        tick();

        // Core 2 reads address 5
        set_core(2, 1'b0, 16'd5, 16'h0);
        bus.core_req[2] = 1'b1;
        tick();
        check("c2_mem_re",   32'(bus.mem_re), 32'd1);
        check("c2_mem_we",   32'(bus.mem_we), 32'd0);
        check("c2_mem_addr", 32'(bus.mem_addr), 32'd5);
        check("c2_grant",    32'(bus.grant_id), 32'd2);
        check("c2_busy",     32'(bus.busy), 32'd1);
        tick();
        check("c2_ack",      32'(bus.core_ack), 32'h4);
        check("c2_rdata",    32'(bus.core_rdata), 32'h1234);
        check("c2_host_ack", 32'(bus.host_ack), 32'd0);
        bus.core_req[2] = 1'b0;
        tick();
        check("c2_ack_done", 32'(bus.core_ack), 32'd0);
        check("c2_idle",     32'(bus.busy), 32'd0);
        check("c2_hold",     32'(bus.core_rdata), 32'h1234);

        // Core 3 writes 0xBEEF to 997, host reads it back
        we_snap = we_pulses;
        set_core(3, 1'b1, 16'd997, 16'hBEEF);
        bus.core_req[3] = 1'b1;
        tick();
        check("c3_mem_we",    32'(bus.mem_we), 32'd1);
        check("c3_mem_re",    32'(bus.mem_re), 32'd0);
        check("c3_mem_addr",  32'(bus.mem_addr), 32'd997);
        check("c3_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        tick();
        check("c3_ack",        32'(bus.core_ack), 32'h8);
        check("c3_rdata_hold", 32'(bus.core_rdata), 32'h1234);
        bus.core_req[3] = 1'b0;
        host_xfer(1'b0, 16'd997, 16'h0);
        check("h_rdata",     32'(bus.host_rdata), 32'hBEEF);
        check("h_core_ack",  32'(bus.core_ack), 32'd0);
        check("we_pulses",   32'(we_pulses - we_snap), 32'd1);
        tick();
        check("h_rdata_hold", 32'(bus.host_rdata), 32'hBEEF);

        // Host and core 1 request in the same cycle: host first, core 1 three cycles later
        set_core(1, 1'b0, 16'd997, 16'h0);
        bus.host_we   = 1'b0;
        bus.host_addr = 16'd5;
        bus.host_req  = 1'b1;
        bus.core_req[1] = 1'b1;
        tick();
        check("pri_grant_host", 32'(bus.grant_id), 32'd4);
        tick();
        check("pri_host_ack",   32'(bus.host_ack), 32'd1);
        check("pri_core_quiet", 32'(bus.core_ack), 32'd0);
        check("pri_host_rdata", 32'(bus.host_rdata), 32'h1234);
        bus.host_req = 1'b0;
        tick();
        check("pri_gap_ack", 32'(bus.core_ack), 32'd0);
        tick();
        check("pri_grant_c1", 32'(bus.grant_id), 32'd1);
        check("pri_c1_re",    32'(bus.mem_re), 32'd1);
        tick();
        check("pri_c1_ack",   32'(bus.core_ack), 32'h2);
        check("pri_c1_rdata", 32'(bus.core_rdata), 32'hBEEF);
        check("pri_h_quiet",  32'(bus.host_ack), 32'd0);
        bus.core_req[1] = 1'b0;
        tick();

        // Reset during the ACCESS of a core-1 write
        we_snap = we_pulses;
        set_core(1, 1'b1, 16'd5, 16'hAAAA);
        bus.core_req[1] = 1'b1;
        tick();
        check("rst_pre_we", 32'(bus.mem_we), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        tick();
        check("rst_no_ack", 32'(bus.core_ack), 32'd0);
        bus.core_req[1] = 1'b0;
        RESET = 1'b0;
        check("rst_no_write", 32'(we_pulses - we_snap), 32'd0);
        host_xfer(1'b0, 16'd5, 16'h0);
        check("rst_mem_kept", 32'(bus.host_rdata), 32'h1234);
        tick();

        // All four cores contend continuously after reset: 0,1,2,3,0,1 three cycles apart
        for (int i = 0; i < 4; i++) set_core(i, 1'b0, 16'(10 + i), 16'h0);
        reraise = '0;
        bus.core_req = 4'hF;
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            tick();
            bus.core_req = bus.core_req | reraise;
            reraise = '0;
            if (bus.core_ack != '0) begin
                check("rr_onehot", 32'($countones(bus.core_ack)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (bus.core_ack[i]) begin
                        order.push_back(i);
                        ack_cyc.push_back(c);
                    end
                end
                reraise      = bus.core_ack;
                bus.core_req = bus.core_req & ~bus.core_ack;
            end
        end
        bus.core_req = '0;
        check("rr_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));
        for (int i = 1; i < ack_cyc.size(); i++)
            check($sformatf("rr_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        repeat (2) tick();
        check("end_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
